flex_pts_stuff_sr: RTL and testbench

Parametrised parallel-to-serial transmit shifter for the USB TX path, successor to the fixed 8-bit PtS wrapper. Accepts words over a valid/ready handshake into a one-word holding buffer, so back-to-back words serialize with no gap. Inserts USB bit-stuffing zeros and produces both the stuffed raw line bit and its NRZI-encoded form. Sits between the TX packet FSM/FIFO and the D+/D- encoder; one bit leaves per bit_strobe.

---
 rtl/pts_pkg.sv | 12 +
 rtl/flex_counter.sv | 34 +++
 rtl/flex_pts_stuff_sr.sv | 169 ++++++++++++++++
 tb/tb_flex_pts_stuff_sr.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pts_pkg.sv
// Shared types and constants for the USB parallel-to-serial transmit shifter.
package pts_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StStuff
  } pts_state_e;

  localparam int unsigned USB_STUFF_RUN = 6;

endpackage

// File: rtl/flex_counter.sv
// Bit counter for the transmit shifter: counts 0..rollover-1 and wraps, with sync clear.
module flex_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] rollover_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == rollover_i - 1'b1) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/flex_pts_stuff_sr.sv
// USB TX parallel-to-serial shifter with one-word holding buffer, bit stuffing and NRZI.
module flex_pts_stuff_sr
  import pts_pkg::*;
#(
  parameter int unsigned NUM_BITS   = 8,
  parameter bit          SHIFT_MSB  = 1'b0,
  parameter int unsigned STUFF_RUN  = USB_STUFF_RUN,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                bit_strobe,
  input  logic                data_valid,
  input  logic [NUM_BITS-1:0] data_in,
  output logic                data_ready,
  output logic                serial_out,
  output logic                nrzi_out,
  output logic                stuff_bit,
  output logic                word_done,
  output logic                busy
);

  localparam int unsigned BitW  = $clog2(NUM_BITS + 1);
  localparam int unsigned OnesW = $clog2(STUFF_RUN + 1);

  pts_state_e          state_q, state_d;
  logic [NUM_BITS-1:0] sr_q, sr_d, hold_q, hold_d;
  logic                sr_full_q, sr_full_d, hold_full_q, hold_full_d;
  logic [OnesW-1:0]    ones_q, ones_d;
  logic                serial_q, serial_d, nrzi_q, nrzi_d;
  logic                stuff_q, stuff_d, done_q, done_d;

  logic [BitW-1:0] bit_cnt;
  logic            load, cnt_en, raw_bit, last_bit, stuff_due;

  assign raw_bit   = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];
  assign last_bit  = (bit_cnt == BitW'(NUM_BITS - 1));
  assign stuff_due = raw_bit && (ones_q == OnesW'(STUFF_RUN - 1));

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    sr_full_d   = sr_full_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ones_d      = ones_q;
    serial_d    = serial_q;
    nrzi_d      = nrzi_q;
    stuff_d     = stuff_q;
    done_d      = 1'b0;
    load        = 1'b0;
    cnt_en      = 1'b0;

    if (!bit_strobe) begin
      if (!sr_full_q && hold_full_q) begin
        load      = 1'b1;
        sr_d      = hold_q;
        sr_full_d = 1'b1;
        if (state_q == StIdle) state_d = StShift;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          serial_d = IDLE_LEVEL;
          stuff_d  = 1'b0;
          ones_d   = '0;
        end
        StShift: begin
          serial_d = raw_bit;
          stuff_d  = 1'b0;
          nrzi_d   = raw_bit ? nrzi_q : ~nrzi_q;
          sr_d     = SHIFT_MSB ? (sr_q << 1) : (sr_q >> 1);
          ones_d   = raw_bit ? ones_q + 1'b1 : '0;
          cnt_en   = 1'b1;
          if (last_bit) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              load = 1'b1;
              sr_d = hold_q;
            end else begin
              sr_full_d = 1'b0;
            end
          end
          // A stuff owed after the final bit still goes out, even with nothing to reload.
          if (stuff_due) begin
            state_d = StStuff;
          end else if (last_bit && !hold_full_q) begin
            state_d = StIdle;
          end
        end
        StStuff: begin
          serial_d = 1'b0;
          stuff_d  = 1'b1;
          nrzi_d   = ~nrzi_q;
          ones_d   = '0;
          state_d  = sr_full_q ? StShift : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (load) hold_full_d = 1'b0;
    if (data_valid && !hold_full_q) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    if (clear) begin
      state_d     = StIdle;
      sr_d        = '0;
      sr_full_d   = 1'b0;
      hold_d      = '0;
      hold_full_d = 1'b0;
      ones_d      = '0;
      serial_d    = IDLE_LEVEL;
      nrzi_d      = 1'b1;
      stuff_d     = 1'b0;
      done_d      = 1'b0;
      load        = 1'b0;
      cnt_en      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      sr_full_q   <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ones_q      <= '0;
      serial_q    <= IDLE_LEVEL;
      nrzi_q      <= 1'b1;
      stuff_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      sr_full_q   <= sr_full_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ones_q      <= ones_d;
      serial_q    <= serial_d;
      nrzi_q      <= nrzi_d;
      stuff_q     <= stuff_d;
      done_q      <= done_d;
    end
  end

  flex_counter #(
    .Width (BitW)
  ) u_bit_cnt (
    .clk_i      (clk),
    .rst_ni     (n_rst),
    .clear_i    (clear | load),
    .en_i       (cnt_en),
    .rollover_i (BitW'(NUM_BITS)),
    .count_o    (bit_cnt)
  );

  assign data_ready = ~hold_full_q;
  assign serial_out = serial_q;
  assign nrzi_out   = nrzi_q;
  assign stuff_bit  = stuff_q;
  assign word_done  = done_q;
  assign busy       = sr_full_q | (state_q == StStuff);

endmodule

// File: tb/tb_flex_pts_stuff_sr.sv
// Directed self-checking bench for flex_pts_stuff_sr (default LSB-first and 12-bit MSB-first).
module tb_flex_pts_stuff_sr;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       clear = 1'b0, bit_strobe = 1'b0, data_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_ready, serial_out, nrzi_out, stuff_bit, word_done, busy;

  logic        m_clear = 1'b0, m_strobe = 1'b0, m_valid = 1'b0;
  logic [11:0] m_data = '0;
  logic        m_ready, m_serial, m_nrzi, m_stuff, m_done, m_busy;

  int   n_cmp = 0;
  int   n_err = 0;
  logic nrzi_m = 1'b1;

  always #5 clk = ~clk;

  flex_pts_stuff_sr u_dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .bit_strobe (bit_strobe),
    .data_valid (data_valid),
    .data_in    (data_in),
    .data_ready (data_ready),
    .serial_out (serial_out),
    .nrzi_out   (nrzi_out),
    .stuff_bit  (stuff_bit),
    .word_done  (word_done),
    .busy       (busy)
  );

  flex_pts_stuff_sr #(
    .NUM_BITS  (12),
    .SHIFT_MSB (1'b1)
  ) u_dut_msb (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (m_clear),
    .bit_strobe (m_strobe),
    .data_valid (m_valid),
    .data_in    (m_data),
    .data_ready (m_ready),
    .serial_out (m_serial),
    .nrzi_out   (m_nrzi),
    .stuff_bit  (m_stuff),
    .word_done  (m_done),
    .busy       (m_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  task automatic strobe();
    bit_strobe = 1'b1;
    step();
    bit_strobe = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    gap(2);
    n_rst  = 1'b1;
    nrzi_m = 1'b1;
    step();
  endtask

  task automatic offer(input logic [7:0] w);
    int guard = 0;
    while (!data_ready && guard < 100) begin
      step();
      guard++;
    end
    check_eq("offer_ready", data_ready, 1);
    data_in    = w;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  // One line-carrying strobe; NRZI expectation follows the raw bit.
  task automatic strobe_chk(input string tag, input int gapn, input logic e_ser,
                            input logic e_stuff, input logic e_done);
    gap(gapn);
    strobe();
    if (!e_ser) nrzi_m = ~nrzi_m;
    check_eq({tag, "_ser"}, serial_out, e_ser);
    check_eq({tag, "_nrzi"}, nrzi_out, nrzi_m);
    check_eq({tag, "_stuff"}, stuff_bit, e_stuff);
    check_eq({tag, "_done"}, word_done, e_done);
  endtask

  task automatic m_strobe_step();
    m_strobe = 1'b1;
    step();
    m_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5_nrzi;
    logic [7:0] words [3];
    a5_nrzi  = 8'b1100_1001;
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;

    do_reset();
    check_eq("rst_ser", serial_out, 1);
    check_eq("rst_nrzi", nrzi_out, 1);
    check_eq("rst_ready", data_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", word_done, 0);
    check_eq("rst_m_ready", m_ready, 1);

    // 0xA5 LSB first, strobe every 4 cycles
    offer(8'hA5);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'hA5;
      strobe_chk($sformatf("a5_%0d", i), 3, v[i], 1'b0, i == 7);
      check_eq($sformatf("a5_nrzi_tab_%0d", i), nrzi_out, a5_nrzi[i]);
    end
    check_eq("a5_busy_end", busy, 0);
    gap(3);
    strobe();
    check_eq("a5_idle_ser", serial_out, 1);
    check_eq("a5_idle_nrzi", nrzi_out, nrzi_m);

    // Async reset in the middle of a word
    do_reset();
    offer(8'hA5);
    for (int i = 0; i < 3; i++) begin
      gap(3);
      strobe();
    end
    check_eq("mid_busy_pre", busy, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("mid_ser", serial_out, 1);
    check_eq("mid_nrzi", nrzi_out, 1);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_ready", data_ready, 1);
    check_eq("mid_stuff", stuff_bit, 0);
    n_rst  = 1'b1;
    nrzi_m = 1'b1;
    step();

    // 0xFF then 0x00 back to back: stuff after six ones, no gap between words
    offer(8'hFF);
    offer(8'h00);
    for (int i = 0; i < 17; i++) begin
      strobe_chk($sformatf("ff00_%0d", i), 1, (i < 6) || (i == 7) || (i == 8), i == 6,
                 (i == 8) || (i == 16));
    end
    check_eq("ff00_busy_end", busy, 0);

    // 0x3F alone: stuff lands mid-word, busy falls after the 9th strobe
    offer(8'h3F);
    for (int i = 0; i < 9; i++) begin
      strobe_chk($sformatf("x3f_%0d", i), 2, i < 6, i == 6, i == 8);
      if (i == 7) check_eq("x3f_busy8", busy, 1);
    end
    check_eq("x3f_busy9", busy, 0);
    gap(2);
    strobe();
    check_eq("x3f_idle_ser", serial_out, 1);

    // 0xFC alone: stuff owed after the final bit is still emitted
    offer(8'hFC);
    for (int i = 0; i < 9; i++) begin
      strobe_chk($sformatf("xfc_%0d", i), 2, (i >= 2) && (i < 8), i == 8, i == 7);
      if (i == 7) check_eq("xfc_busy8", busy, 1);
    end
    check_eq("xfc_busy9", busy, 0);

    // Handshake: valid held high for three words while strobes are slow
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          int guard;
          guard      = 0;
          data_in    = words[k];
          data_valid = 1'b1;
          while (!data_ready && guard < 400) begin
            step();
            guard++;
          end
          check_eq($sformatf("hs_ready_%0d", k), data_ready, 1);
          step();
          check_eq($sformatf("hs_full_%0d", k), data_ready, 0);
        end
        data_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          logic [7:0] got;
          got = '0;
          for (int b = 0; b < 8; b++) begin
            gap(5);
            strobe();
            got[b] = serial_out;
          end
          check_eq($sformatf("hs_word_%0d", k), got, words[k]);
        end
      end
    join
    gap(2);
    check_eq("hs_busy_end", busy, 0);
    check_eq("hs_ready_end", data_ready, 1);

    // MSB first, 12-bit word 0x801
    m_data  = 12'h801;
    m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    step();
    for (int i = 0; i < 12; i++) begin
      gap(3);
      m_strobe_step();
      check_eq($sformatf("msb_ser_%0d", i), m_serial, (i == 0) || (i == 11));
      check_eq($sformatf("msb_done_%0d", i), m_done, i == 11);
    end
    check_eq("msb_busy_end", m_busy, 0);

    // Clear mid-word (with a coincident strobe that must be ignored)
    m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      gap(3);
      m_strobe_step();
    end
    check_eq("clr_pre_ser", m_serial, 0);
    check_eq("clr_pre_nrzi", m_nrzi, 0);
    check_eq("clr_pre_busy", m_busy, 1);
    m_clear  = 1'b1;
    m_strobe = 1'b1;
    step();
    m_clear  = 1'b0;
    m_strobe = 1'b0;
    check_eq("clr_ser", m_serial, 1);
    check_eq("clr_nrzi", m_nrzi, 1);
    check_eq("clr_busy", m_busy, 0);
    check_eq("clr_ready", m_ready, 1);
    gap(3);
    m_strobe_step();
    check_eq("clr_idle_ser", m_serial, 1);
    check_eq("clr_idle_nrzi", m_nrzi, 1);
    check_eq("clr_idle_busy", m_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
